// File: rtl/det_job_scheduler_if.sv
`default_nettype none
// ------------------------------------------------------------------
// det_job_scheduler_if: job request and result handshakes of the scheduler
// rev 1.0
// ------------------------------------------------------------------
interface det_job_scheduler_if #(
  parameter int AW = 4,
  parameter int DW = 16
);
  logic          job_valid;
  logic [AW-1:0] job_addr;
  logic          job_ready;
  logic          result_valid;
  logic [DW-1:0] result_data;
  logic [AW-1:0] result_addr;
  logic          result_ready;

  // master: requester/consumer side; slave: the scheduler
  modport master (
    output job_valid, job_addr, result_ready,
    input  job_ready, result_valid, result_data, result_addr
  );

  modport slave (
    input  job_valid, job_addr, result_ready,
    output job_ready, result_valid, result_data, result_addr
  );
endinterface
`default_nettype wire

// File: rtl/det_job_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// det_job_scheduler: queued job sequencer for the 2x2 determinant datapath
// rev 1.0
// ------------------------------------------------------------------
module det_job_scheduler #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  det_job_scheduler_if.slave bus,
  output logic            counter_load,
  output logic            counter_enable,
  output logic [AW-1:0]   start_address,
  output logic            decoder_enable,
  output logic [1:0]      Radd,
  output logic            sel,
  input  logic [DW-1:0]   det_in,
  output logic            busy,
  output logic [7:0]      jobs_done
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_RD0    = 4'd2,
    S_RD1    = 4'd3,
    S_RD2    = 4'd4,
    S_RD3    = 4'd5,
    S_MUL_AD = 4'd6,
    S_MUL_BC = 4'd7,
    S_CAPT   = 4'd8
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_next;
  logic          job_rdy;
  logic          push, pop;
  logic          fifo_nonempty;
  logic          capture;
  logic [AW-1:0] cur_addr;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_addr;

  assign push          = bus.job_valid & job_rdy;
  assign fifo_nonempty = (count != '0);
  assign capture       = (state == S_CAPT) & (~res_valid | bus.result_ready);

  assign bus.job_ready    = job_rdy;
  assign bus.result_valid = res_valid;
  assign bus.result_data  = res_data;
  assign bus.result_addr  = res_addr;
  assign busy             = (state != S_IDLE);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    counter_load   = 1'b0;
    counter_enable = 1'b0;
    start_address  = '0;
    decoder_enable = 1'b0;
    Radd           = 2'd0;
    sel            = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_nonempty) begin
          state_next = S_LOAD;
          pop        = 1'b1;
        end
      end
      S_LOAD: begin
        counter_load  = 1'b1;
        start_address = cur_addr;
        state_next    = S_RD0;
      end
      S_RD0: begin
        decoder_enable = 1'b1;
        Radd           = 2'd0;
        counter_enable = 1'b1;
        state_next     = S_RD1;
      end
      S_RD1: begin
        decoder_enable = 1'b1;
        Radd           = 2'd1;
        counter_enable = 1'b1;
        state_next     = S_RD2;
      end
      S_RD2: begin
        decoder_enable = 1'b1;
        Radd           = 2'd2;
        counter_enable = 1'b1;
        state_next     = S_RD3;
      end
      // counter stays on addr+3 so D is the last word read
      S_RD3: begin
        decoder_enable = 1'b1;
        Radd           = 2'd3;
        state_next     = S_MUL_AD;
      end
      S_MUL_AD: state_next = S_MUL_BC;
      S_MUL_BC: begin
        sel        = 1'b1;
        state_next = S_CAPT;
      end
      S_CAPT: begin
        sel = 1'b1;
        if (capture) begin
          if (fifo_nonempty) begin
            state_next = S_LOAD;
            pop        = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.job_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      job_rdy   <= 1'b0;
      cur_addr  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_addr  <= '0;
      jobs_done <= 8'd0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      // ready follows occupancy only; a pop on a full FIFO does not reopen it this cycle
      job_rdy <= (count_next != FULL);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        cur_addr <= fifo_mem[rd_ptr];
      end
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= det_in;
        res_addr  <= cur_addr;
      end else if (bus.result_ready) begin
        res_valid <= 1'b0;
      end
      if (res_valid & bus.result_ready) jobs_done <= jobs_done + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_det_job_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_det_job_scheduler: directed bench with a behavioural ROM/multiplier datapath
// rev 1.0
// ------------------------------------------------------------------
module tb_det_job_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        counter_load, counter_enable, decoder_enable, sel, busy;
  logic [3:0]  start_address;
  logic [1:0]  Radd;
  logic [15:0] det_in;
  logic [7:0]  jobs_done;

  int n_total = 0;
  int n_bad   = 0;

  det_job_scheduler_if #(.AW(4), .DW(16)) bus ();

  det_job_scheduler #(.DEPTH(4), .AW(4), .DW(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .counter_load   (counter_load),
    .counter_enable (counter_enable),
    .start_address  (start_address),
    .decoder_enable (decoder_enable),
    .Radd           (Radd),
    .sel            (sel),
    .det_in         (det_in),
    .busy           (busy),
    .jobs_done      (jobs_done)
  );

  always #5 clk = ~clk;

  // datapath: ROM, counter, A..D register file, shared multiplier, E/F, subtractor
  logic [7:0]         rom [16];
  logic [3:0]         cnt = 4'd0;
  logic [7:0]         rf [4];
  logic signed [15:0] e_reg = 16'sd0;
  logic signed [15:0] f_reg = 16'sd0;
  logic [7:0]         dout;

  assign dout   = rom[cnt];
  assign det_in = f_reg - e_reg;

  always @(posedge clk) begin
    if (counter_load) cnt <= start_address;
    else if (counter_enable) cnt <= cnt + 4'd1;
    if (decoder_enable) rf[Radd] <= dout;
    if (sel) e_reg <= $signed(rf[1]) * $signed(rf[2]);
    else     f_reg <= $signed(rf[0]) * $signed(rf[3]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] det_of(input logic [3:0] a);
    logic signed [7:0]  va, vb, vc, vd;
    logic signed [15:0] pad, pbc;
    va  = rom[a];
    vb  = rom[a + 4'd1];
    vc  = rom[a + 4'd2];
    vd  = rom[a + 4'd3];
    pad = va * vd;
    pbc = vb * vc;
    return pad - pbc;
  endfunction

  // called at a negedge, returns at the negedge after acceptance
  task automatic push(input logic [3:0] a);
    int n = 0;
    bus.job_valid = 1'b1;
    bus.job_addr  = a;
    while (!bus.job_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("push_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.job_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [3:0] ea, input logic [15:0] ed);
    int n = 0;
    while (!bus.result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_wait"}, 32'(n < 100), 32'd1);
    check_eq({tag, "_addr"}, 32'(bus.result_addr), 32'(ea));
    check_eq({tag, "_data"}, 32'(bus.result_data), 32'(ed));
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] q4 [6];
    logic [3:0] q6 [8];
    int lat;
    q4 = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd2, 4'd6};
    q6 = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
    for (int i = 0; i < 16; i++) rom[i] = 8'd0;
    rst              = 1'b1;
    bus.job_valid    = 1'b0;
    bus.job_addr     = 4'd0;
    bus.result_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rvalid", 32'(bus.result_valid), 32'd0);
    check_eq("rst_jready", 32'(bus.job_ready), 32'd0);
    check_eq("rst_jobs", 32'(jobs_done), 32'd0);
    check_eq("rst_ctrl", 32'({counter_load, counter_enable, decoder_enable, sel}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("jready_after_rst", 32'(bus.job_ready), 32'd1);

    // basic job and latency
    rom[0] = 8'd3; rom[1] = 8'd2; rom[2] = 8'd1; rom[3] = 8'd4;
    push(4'd0);
    @(negedge clk);
    check_eq("t1_load", 32'(counter_load), 32'd1);
    check_eq("t1_start", 32'(start_address), 32'd0);
    lat = 0;
    while (!bus.result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("t1_latency", 32'(lat), 32'd8);
    collect("t1", 4'd0, 16'd10);
    check_eq("t1_jobs", 32'(jobs_done), 32'd1);
    check_eq("t1_drained", 32'(bus.result_valid), 32'd0);

    // negative result
    rom[4] = 8'hFE; rom[5] = 8'd5; rom[6] = 8'd3; rom[7] = 8'd7;
    push(4'd4);
    collect("t2", 4'd4, 16'hFFE3);

    // address wrap
    rom[14] = 8'd1; rom[15] = 8'd2; rom[0] = 8'd3; rom[1] = 8'd4;
    push(4'd14);
    collect("t3", 4'd14, 16'hFFFE);
    check_eq("t3_jobs", 32'(jobs_done), 32'd3);

    // reset in RD2 with a second job queued
    rom[8] = 8'd6; rom[9] = 8'd1; rom[10] = 8'd2; rom[11] = 8'd3;
    push(4'd8);
    push(4'd4);
    check_eq("t5_load", 32'(counter_load), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t5_rd2", 32'({decoder_enable, Radd, counter_enable}), 32'b1101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_ctrl", 32'({counter_load, counter_enable, decoder_enable, sel, Radd}), 32'd0);
    check_eq("t5_rvalid", 32'(bus.result_valid), 32'd0);
    check_eq("t5_jobs", 32'(jobs_done), 32'd0);
    check_eq("t5_jready_rst", 32'(bus.job_ready), 32'd0);
    @(negedge clk);
    check_eq("t5_jready", 32'(bus.job_ready), 32'd1);
    repeat (5) @(negedge clk);
    check_eq("t5_fifo_empty", 32'(busy), 32'd0);
    push(4'd8);
    collect("t5", 4'd8, 16'h0010);

    // stalled consumer, FIFO fills, drain in order
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) rom[i] = 8'((i * 37) ^ 8'h5A);
    bus.result_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(q4[i]);
    repeat (20) @(negedge clk);
    check_eq("t4_full", 32'(bus.job_ready), 32'd0);
    check_eq("t4_stall_sel", 32'({busy, sel}), 32'b11);
    check_eq("t4_hold_valid", 32'(bus.result_valid), 32'd1);
    check_eq("t4_hold_addr", 32'(bus.result_addr), 32'(q4[0]));
    check_eq("t4_hold_data", 32'(bus.result_data), 32'(det_of(q4[0])));
    bus.result_ready = 1'b1;
    for (int i = 0; i < 6; i++) collect("t4", q4[i], det_of(q4[i]));
    check_eq("t4_jobs", 32'(jobs_done), 32'd6);
    check_eq("t4_jready", 32'(bus.job_ready), 32'd1);

    // streaming pushes against pops on a full FIFO
    fork
      begin
        for (int i = 0; i < 8; i++) push(q6[i]);
      end
      begin
        for (int j = 0; j < 8; j++) collect("t6", q6[j], det_of(q6[j]));
      end
    join
    repeat (3) @(negedge clk);
    check_eq("t6_jobs", 32'(jobs_done), 32'd14);
    check_eq("t6_idle", 32'({busy, bus.result_valid}), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
